dnn_batch_feeder: RTL and testbench

- Host-side transmitter for the dnn_top input interface.
- Accepts a serial stream of 5-bit signed words (valid/ready) and assembles one batch: 4 inputs, 16 layer-1 weights and 8 layer-2 weights.
- Replays the batch to dnn_top on the fixed in_ready schedule, then collects out0/out1 and returns them to the host on a result handshake.

---
 rtl/dnn_batch_feeder_if.sv | 27 ++
 rtl/dnn_batch_feeder.sv | 135 +++++++++++++
 tb/tb_dnn_batch_feeder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_batch_feeder_if.sv
// Host-side stream and result handshake of dnn_batch_feeder.
// master = host, slave = feeder.
`timescale 1ns/1ps
interface dnn_batch_feeder_if #(
  parameter int I_W = 5,
  parameter int O_W = 18
);
  logic [I_W-1:0] s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic [O_W-1:0] res0;
  logic [O_W-1:0] res1;
  logic           res_valid;
  logic           res_err;
  logic           res_ready;

  modport master (
    output s_data, s_valid, s_last, res_ready,
    input  s_ready, res0, res1, res_valid, res_err
  );

  modport slave (
    input  s_data, s_valid, s_last, res_ready,
    output s_ready, res0, res1, res_valid, res_err
  );
endinterface

// File: rtl/dnn_batch_feeder.sv
// Assembles a 28-word batch from the host, replays it to dnn_top on the fixed
// in_ready schedule, then returns out0/out1 (or a timeout flag) to the host.
`timescale 1ns/1ps
module dnn_batch_feeder #(
  parameter int I_W     = 5,
  parameter int O_W     = 18,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  dnn_batch_feeder_if.slave   host,
  output logic [4*I_W-1:0]    x_bus,
  output logic [16*I_W-1:0]   w1_bus,
  output logic [8*I_W-1:0]    w2_bus,
  output logic                in_ready,
  input  logic [O_W-1:0]      out0,
  input  logic [O_W-1:0]      out1,
  input  logic                out0_ready,
  input  logic                out1_ready,
  output logic                frame_err,
  output logic [15:0]         batch_cnt
);

  localparam int N_WORDS = 28;
  localparam int TW      = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {LOAD, SEND, WAIT, RESULT} state_t;

  state_t         state, state_nxt;
  logic [I_W-1:0] stage [N_WORDS];
  logic [4:0]     idx;
  logic [2:0]     k;
  logic [TW-1:0]  tcnt;
  logic           got0, got1, s_ready_q, res_err_q, res_valid_c;
  logic [O_W-1:0] res0_q, res1_q;
  logic           accept, last_idx, good_end, bad_end;
  logic           cap_en, cap0, cap1, both, timeout;

  assign host.s_ready   = s_ready_q;
  assign host.res0      = res0_q;
  assign host.res1      = res1_q;
  assign host.res_err   = res_err_q;
  assign host.res_valid = res_valid_c;

  always_comb begin
    accept   = host.s_valid && s_ready_q && (state == LOAD);
    last_idx = (idx == 5'(N_WORDS - 1));
    good_end = accept && host.s_last && last_idx;
    bad_end  = accept && (host.s_last != last_idx);
    // Capture is armed from the first SEND cycle so early results are kept.
    cap_en   = (state == SEND) || (state == WAIT);
    cap0     = cap_en && out0_ready && !got0;
    cap1     = cap_en && out1_ready && !got1;
    both     = (got0 || cap0) && (got1 || cap1);
    timeout  = (state == WAIT) && (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (good_end)          state_nxt = SEND;
      SEND:    if (k == 3'd4)         state_nxt = WAIT;
      WAIT:    if (both || timeout)   state_nxt = RESULT;
      RESULT:  if (host.res_ready)    state_nxt = LOAD;
      default:                        state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready    = (state == SEND);
    res_valid_c = (state == RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_WORDS; i++) stage[i] <= '0;
      idx       <= '0;
      k         <= '0;
      tcnt      <= '0;
      got0      <= 1'b0;
      got1      <= 1'b0;
      s_ready_q <= 1'b0;
      res_err_q <= 1'b0;
      res0_q    <= '0;
      res1_q    <= '0;
      x_bus     <= '0;
      w1_bus    <= '0;
      w2_bus    <= '0;
      frame_err <= 1'b0;
      batch_cnt <= '0;
    end else begin
      s_ready_q <= (state_nxt == LOAD);
      frame_err <= bad_end;
      if (accept) begin
        idx <= (bad_end || good_end) ? '0 : idx + 5'd1;
        if (!bad_end) stage[idx] <= host.s_data;
      end
      // Buses are registered, so each loads one cycle ahead of its k slot.
      if (good_end) begin
        for (int unsigned i = 0; i < 4; i++) x_bus[i*I_W +: I_W] <= stage[i];
        k         <= '0;
        got0      <= 1'b0;
        got1      <= 1'b0;
        res0_q    <= '0;
        res1_q    <= '0;
        res_err_q <= 1'b0;
      end
      if (state == SEND) begin
        k    <= k + 3'd1;
        tcnt <= '0;
        if (k == 3'd0)
          for (int unsigned i = 0; i < 16; i++) w1_bus[i*I_W +: I_W] <= stage[4+i];
        if (k == 3'd3)
          for (int unsigned i = 0; i < 8; i++) w2_bus[i*I_W +: I_W] <= stage[20+i];
      end
      if (state == WAIT) tcnt <= tcnt + TW'(1);
      if (cap0) begin
        res0_q <= out0;
        got0   <= 1'b1;
      end
      if (cap1) begin
        res1_q <= out1;
        got1   <= 1'b1;
      end
      if ((state == WAIT) && (state_nxt == RESULT)) res_err_q <= !both;
      if ((state == RESULT) && host.res_ready) batch_cnt <= batch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dnn_batch_feeder.sv
// Randomised bench for dnn_batch_feeder: a timeline-based reference model,
// a per-cycle compare process and directed literal checks.
`timescale 1ns/1ps
module tb_dnn_batch_feeder;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] x_bus;
  logic [79:0] w1_bus;
  logic [39:0] w2_bus;
  logic        in_ready, frame_err;
  logic [17:0] out0 = '0, out1 = '0;
  logic        out0_ready = 1'b0, out1_ready = 1'b0;
  logic [15:0] batch_cnt;

  dnn_batch_feeder_if #(.I_W(5), .O_W(18)) hif ();

  dnn_batch_feeder #(.I_W(5), .O_W(18), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (hif),
    .x_bus      (x_bus),
    .w1_bus     (w1_bus),
    .w2_bus     (w2_bus),
    .in_ready   (in_ready),
    .out0       (out0),
    .out1       (out1),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .frame_err  (frame_err),
    .batch_cnt  (batch_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;
  int n_batches = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timeline of the current batch) -------
  int          cyc = 0;
  int          t0 = 0;
  int          mk;
  bit          m_load = 1'b1, m_inres = 1'b0, m_got0 = 1'b0, m_got1 = 1'b0;
  logic [4:0]  mq[$];
  logic [4:0]  mb [28];
  logic [19:0] e_x = '0;
  logic [79:0] e_w1 = '0;
  logic [39:0] e_w2 = '0;
  logic [17:0] e_r0 = '0, e_r1 = '0;
  bit          e_err = 1'b0, e_frame = 1'b0, e_sready = 1'b0, e_ir = 1'b0;
  logic [15:0] e_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load = 1'b1; m_inres = 1'b0; m_got0 = 1'b0; m_got1 = 1'b0;
      mq.delete();
      e_x = '0; e_w1 = '0; e_w2 = '0; e_r0 = '0; e_r1 = '0;
      e_err = 1'b0; e_frame = 1'b0; e_sready = 1'b0; e_ir = 1'b0; e_cnt = '0;
    end else begin
      cyc++;
      e_frame = 1'b0;
      if (m_load) begin
        if (e_sready && hif.s_valid) begin
          mq.push_back(hif.s_data);
          if (hif.s_last || mq.size() == 28) begin
            if (hif.s_last && mq.size() == 28) begin
              m_load = 1'b0; t0 = cyc;
              for (int i = 0; i < 28; i++) mb[i] = mq[i];
              for (int i = 0; i < 4; i++) e_x[i*5 +: 5] = mb[i];
              m_got0 = 1'b0; m_got1 = 1'b0; e_r0 = '0; e_r1 = '0; e_err = 1'b0;
            end else begin
              e_frame = 1'b1;
            end
            mq.delete();
          end
        end
      end else if (m_inres) begin
        if (hif.res_ready) begin
          m_inres = 1'b0; m_load = 1'b1; e_cnt = e_cnt + 16'd1;
        end
      end else begin
        mk = cyc - t0;
        if (mk == 1) for (int i = 0; i < 16; i++) e_w1[i*5 +: 5] = mb[4+i];
        if (mk == 4) for (int i = 0; i < 8; i++)  e_w2[i*5 +: 5] = mb[20+i];
        if (out0_ready && !m_got0) begin m_got0 = 1'b1; e_r0 = out0; end
        if (out1_ready && !m_got1) begin m_got1 = 1'b1; e_r1 = out1; end
        if (mk >= 6 && ((m_got0 && m_got1) || mk == 5 + TMO)) begin
          m_inres = 1'b1;
          e_err = !(m_got0 && m_got1);
        end
      end
      e_sready = m_load;
      e_ir = !m_load && !m_inres && (cyc - t0) <= 4;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("s_ready", hif.s_ready, e_sready);
      chk("in_ready", in_ready, e_ir);
      chk("frame_err", frame_err, e_frame);
      chk("res_valid", hif.res_valid, m_inres);
      chk("x_bus", x_bus, e_x);
      chk("w1_bus", w1_bus, e_w1);
      chk("w2_bus", w2_bus, e_w2);
      chk("batch_cnt", batch_cnt, e_cnt);
      if (m_inres) begin
        chk("res0", hif.res0, e_r0);
        chk("res1", hif.res1, e_r1);
        chk("res_err", hif.res_err, e_err);
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  int          cur [28];
  logic [19:0] snap_x;
  logic [79:0] snap_w1_0, snap_w1;
  logic [39:0] snap_w2_3, snap_w2;

  function automatic int dnn(input int o);
    int acc = 0;
    for (int j = 0; j < 4; j++) begin
      int h = 0;
      for (int i = 0; i < 4; i++) h += cur[i] * cur[4 + i*4 + j];
      acc += h * cur[20 + 2*j + o];
    end
    return acc;
  endfunction

  task automatic rnd_cur();
    for (int i = 0; i < 28; i++) cur[i] = int'($urandom_range(0, 31)) - 16;
  endtask

  task automatic unit_cur();
    for (int i = 0; i < 28; i++) cur[i] = (i < 4) ? i + 1 : 1;
  endtask

  task automatic send_words(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      bit acc;
      if ($urandom_range(0, 3) == 0) begin
        hif.s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      hif.s_valid = 1'b1;
      hif.s_data  = 5'(cur[i]);
      hif.s_last  = (i == last_at);
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        acc = hif.s_ready;
        @(negedge clk);
      end
      if (!acc) chk("accept_wait", hif.s_ready, 1);
    end
    hif.s_valid = 1'b0;
    hif.s_last  = 1'b0;
  endtask

  // Called at the negedge of SEND cycle k=0; returns at the first RESULT cycle.
  task automatic respond(input int d0, input int d0b, input int d1,
                         input logic [17:0] v0, input logic [17:0] v0b,
                         input logic [17:0] v1, input bit keep_valid,
                         output int kres, output int irc);
    kres = -1;
    irc  = 0;
    for (int k = 0; k < 60; k++) begin
      out0_ready = (k == d0) || (k == d0b);
      out0 = (k == d0) ? v0 : (k == d0b) ? v0b : 18'($urandom);
      out1_ready = (k == d1);
      out1 = (k == d1) ? v1 : 18'($urandom);
      if (keep_valid) begin hif.s_valid = 1'b1; hif.s_data = 5'($urandom); end
      if (k == 0) begin snap_x = x_bus; snap_w1_0 = w1_bus; end
      if (k == 1) snap_w1 = w1_bus;
      if (k == 3) snap_w2_3 = w2_bus;
      if (k == 4) snap_w2 = w2_bus;
      if (in_ready) irc++;
      if (hif.res_valid) begin kres = k; break; end
      @(negedge clk);
    end
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    if (kres < 0) chk("res_valid_wait", hif.res_valid, 1);
  endtask

  task automatic handshake(input int hold, input bit keep_valid);
    int sr = 0;
    for (int i = 0; i < hold; i++) begin
      if (keep_valid) begin hif.s_valid = 1'b1; hif.s_data = 5'($urandom); end
      sr += int'(hif.s_ready);
      @(negedge clk);
    end
    hif.res_ready = 1'b1;
    @(negedge clk);
    hif.res_ready = 1'b0;
    hif.s_valid   = 1'b0;
    hif.s_last    = 1'b0;
    n_batches++;
    if (keep_valid) chk("hold_s_ready", sr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kres, irc, fe, ir, d0, d1;
    logic [17:0] v0;
    hif.s_data = '0; hif.s_valid = 1'b0; hif.s_last = 1'b0; hif.res_ready = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("cnt_in_reset", batch_cnt, 0);
    chk("x_in_reset", x_bus, 0);
    #2 rst_n = 1'b1;
    #1 chk("s_ready_at_release", hif.s_ready, 0);
    @(negedge clk);
    chk("s_ready_after_release", hif.s_ready, 1);

    // Single batch: x={1,2,3,4}, all weights 1 -> 40/40
    unit_cur();
    send_words(28, 27);
    respond(7, -1, 7, 18'(dnn(0)), '0, 18'(dnn(1)), 1'b0, kres, irc);
    chk("t1_in_ready_cycles", irc, 5);
    chk("t1_result_k", kres, 8);
    chk("t1_x_k0", snap_x, {5'd4, 5'd3, 5'd2, 5'd1});
    chk("t1_w1_k0_old", snap_w1_0, 0);
    chk("t1_w1_k1", snap_w1, {16{5'd1}});
    chk("t1_w2_k3_old", snap_w2_3, 0);
    chk("t1_w2_k4", snap_w2, {8{5'd1}});
    chk("t1_res0", hif.res0, 18'd40);
    chk("t1_res1", hif.res1, 18'd40);
    chk("t1_res_err", hif.res_err, 0);
    handshake(0, 1'b0);
    chk("t1_batch_cnt", batch_cnt, 1);

    // Early s_last on word index 10
    rnd_cur();
    send_words(11, 10);
    fe = 0; ir = 0;
    for (int i = 0; i < 6; i++) begin
      fe += int'(frame_err); ir += int'(in_ready);
      @(negedge clk);
    end
    chk("t2_frame_pulses", fe, 1);
    chk("t2_no_in_ready", ir, 0);
    rnd_cur();
    send_words(28, 27);
    respond(5, -1, 6, 18'(dnn(0)), '0, 18'(dnn(1)), 1'b0, kres, irc);
    handshake(1, 1'b0);
    chk("t2_batch_cnt", batch_cnt, n_batches);

    // Staggered results with a second out0 pulse
    rnd_cur();
    send_words(28, 27);
    respond(6, 8, 9, 18'h3FF9C, 18'd77, 18'd255, 1'b0, kres, irc);
    chk("t3_result_k", kres, 10);
    chk("t3_res0", hif.res0, 18'h3FF9C);
    chk("t3_res1", hif.res1, 18'd255);
    chk("t3_res_err", hif.res_err, 0);
    handshake(0, 1'b0);

    // out1 never arrives -> timeout
    rnd_cur();
    send_words(28, 27);
    v0 = 18'h00123;
    respond(3, -1, -1, v0, '0, '0, 1'b0, kres, irc);
    chk("t4_result_k", kres, 13);
    chk("t4_res_err", hif.res_err, 1);
    chk("t4_res1", hif.res1, 0);
    chk("t4_res0", hif.res0, 18'h00123);
    handshake(2, 1'b0);
    chk("t4_batch_cnt", batch_cnt, n_batches);

    // Host stalls the result for 20 cycles with s_valid high
    rnd_cur();
    send_words(28, 27);
    respond(2, -1, 4, 18'(dnn(0)), '0, 18'(dnn(1)), 1'b1, kres, irc);
    handshake(20, 1'b1);
    rnd_cur();
    send_words(28, 27);
    respond(7, -1, 7, 18'(dnn(0)), '0, 18'(dnn(1)), 1'b0, kres, irc);
    chk("t5_next_result_k", kres, 8);
    handshake(0, 1'b0);

    // Randomised batches with occasional framing faults
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd_cur();
        if ($urandom_range(0, 1) == 1) begin
          int li = int'($urandom_range(0, 26));
          send_words(li + 1, li);
        end else begin
          send_words(28, -1);
        end
        repeat (2) @(negedge clk);
      end
      rnd_cur();
      send_words(28, 27);
      d0 = int'($urandom_range(0, 14));
      d1 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 14));
      respond(d0, ($urandom_range(0, 1) == 1) ? d0 + 2 : -1, d1,
              18'(dnn(0)), 18'($urandom), 18'(dnn(1)), 1'($urandom_range(0, 1)), kres, irc);
      handshake(int'($urandom_range(0, 3)), 1'b0);
    end
    chk("rand_batch_cnt", batch_cnt, 16'(n_batches));

    // Reset in SEND k=2
    rnd_cur();
    send_words(28, 27);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_in_ready_rst", in_ready, 0);
    chk("t6_x_rst", x_bus, 0);
    chk("t6_w1_rst", w1_bus, 0);
    chk("t6_w2_rst", w2_bus, 0);
    chk("t6_cnt_rst", batch_cnt, 0);
    n_batches = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    unit_cur();
    send_words(28, 27);
    respond(7, -1, 7, 18'(dnn(0)), '0, 18'(dnn(1)), 1'b0, kres, irc);
    chk("t6_res0", hif.res0, 18'd40);
    chk("t6_res1", hif.res1, 18'd40);
    handshake(0, 1'b0);
    chk("t6_batch_cnt", batch_cnt, 1);

    repeat (3) @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
